// File: rtl/m_pkg.sv
// m_pkg: shared types and helpers for the M-stage memory-operand fetch sequencer.
//   state_e    - sequencer FSM states
//   Size*      - operand size codes (1/2/4/8 bytes)
//   size_bytes - byte count of a size code
//   find_next  - lowest set bit of a 4-entry beat-valid vector at or above a start index
package m_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StDrain
    } state_e;

    localparam logic [1:0] SizeB = 2'd0;
    localparam logic [1:0] SizeH = 2'd1;
    localparam logic [1:0] SizeW = 2'd2;
    localparam logic [1:0] SizeD = 2'd3;

    localparam int unsigned NumBeats = 4;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    // Returns {found, index}; scanning downward leaves the lowest qualifying index.
    function automatic logic [2:0] find_next(input logic [3:0] vld, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (vld[i] && (3'(i) >= from)) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/m_memfetch_if.sv
// m_memfetch_if: single-outstanding read port between the fetch sequencer and the data cache.
//   req_valid/req_addr/req_ready - 8-byte-aligned read request handshake
//   resp_valid/resp_data         - returned little-endian 8-byte beat
//   master: sequencer side; slave: cache side.
interface m_memfetch_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data
    );
endinterface

// File: rtl/m_memfetch_align.sv
// m_memfetch_align: combinational operand aligner.
//   lo_i/hi_i - the two beats covering the operand (hi_i is zero for single-beat operands)
//   off_i     - byte offset of the operand inside lo_i
//   size_i    - size code; bytes above the operand size are zeroed
//   data_o    - aligned, zero-extended operand
module m_memfetch_align
    import m_pkg::*;
(
    input  logic [63:0] lo_i,
    input  logic [63:0] hi_i,
    input  logic [2:0]  off_i,
    input  logic [1:0]  size_i,
    output logic [63:0] data_o
);

    logic [63:0] win;

    assign win = 64'({hi_i, lo_i} >> {off_i, 3'b000});

    always_comb begin
        data_o = win;
        unique case (size_i)
            SizeB:   data_o = {56'd0, win[7:0]};
            SizeH:   data_o = {48'd0, win[15:0]};
            SizeW:   data_o = {32'd0, win[31:0]};
            SizeD:   data_o = win;
            default: data_o = win;
        endcase
    end

endmodule

// File: rtl/m_memfetch.sv
// m_memfetch: memory-operand fetch sequencer at the head of the M stage.
//   clk, rst                 - clock and synchronous active-high reset
//   in_valid/in_ready        - instruction acceptance (in_ready only while idle)
//   flush                    - kill the in-flight instruction
//   mem{1,2}_rd/addr_in/size - per-operand read request
//   cache                    - data cache read port (one request outstanding)
//   out_valid/out_ready      - assembled operands held until accepted
//   mem{1,2}_data/addr       - aligned zero-extended data and captured addresses
// Each operand needs one beat, or two when it crosses an 8-byte boundary. Beats are kept in a
// 4-slot plan (mem1 lo, mem1 hi, mem2 lo, mem2 hi) and issued in slot order, skipping unused slots.
module m_memfetch
    import m_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    input  logic         mem1_rd,
    input  logic         mem2_rd,
    input  logic [31:0]  mem1_addr_in,
    input  logic [31:0]  mem2_addr_in,
    input  logic [1:0]   mem1_size,
    input  logic [1:0]   mem2_size,
    m_memfetch_if.master cache,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  mem1_data,
    output logic [63:0]  mem2_data,
    output logic [31:0]  mem1_addr,
    output logic [31:0]  mem2_addr
);

    state_e                 state_q, state_d;
    logic [3:0]             beat_vld_q, beat_vld_d;
    logic [3:0][28:0]       beat_addr_q, beat_addr_d;
    logic [NumBeats-1:0][63:0] beat_data_q, beat_data_d;
    logic [1:0]             beat_ptr_q, beat_ptr_d;
    logic [31:0]            req_addr_q, req_addr_d;
    logic [31:0]            mem1_addr_q, mem1_addr_d;
    logic [31:0]            mem2_addr_q, mem2_addr_d;
    logic [1:0]             size1_q, size1_d;
    logic [1:0]             size2_q, size2_d;
    logic [1:0]             rd_q, rd_d;

    logic [3:0]       plan_vld;
    logic [3:0][28:0] plan_addr;
    logic [2:0]       first_beat;
    logic [2:0]       next_beat;
    logic [63:0]      align1, align2;

    // Beat plan computed from the upstream operands; captured only on acceptance.
    always_comb begin
        plan_vld[0]  = mem1_rd;
        plan_vld[1]  = mem1_rd &&
                       (({1'b0, mem1_addr_in[2:0]} + size_bytes(mem1_size)) > 4'd8);
        plan_vld[2]  = mem2_rd;
        plan_vld[3]  = mem2_rd &&
                       (({1'b0, mem2_addr_in[2:0]} + size_bytes(mem2_size)) > 4'd8);
        plan_addr[0] = mem1_addr_in[31:3];
        plan_addr[1] = mem1_addr_in[31:3] + 29'd1;
        plan_addr[2] = mem2_addr_in[31:3];
        plan_addr[3] = mem2_addr_in[31:3] + 29'd1;
    end

    assign first_beat = find_next(plan_vld, 3'd0);
    assign next_beat  = find_next(beat_vld_q, {1'b0, beat_ptr_q} + 3'd1);

    always_comb begin
        state_d     = state_q;
        beat_vld_d  = beat_vld_q;
        beat_addr_d = beat_addr_q;
        beat_data_d = beat_data_q;
        beat_ptr_d  = beat_ptr_q;
        req_addr_d  = req_addr_q;
        mem1_addr_d = mem1_addr_q;
        mem2_addr_d = mem2_addr_q;
        size1_d     = size1_q;
        size2_d     = size2_q;
        rd_d        = rd_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && !flush) begin
                    rd_d        = {mem2_rd, mem1_rd};
                    size1_d     = mem1_size;
                    size2_d     = mem2_size;
                    mem1_addr_d = mem1_addr_in;
                    mem2_addr_d = mem2_addr_in;
                    beat_vld_d  = plan_vld;
                    beat_addr_d = plan_addr;
                    // Cleared so unused hi slots and rd=0 operands assemble to zero.
                    beat_data_d = '0;
                    if (first_beat[2]) begin
                        beat_ptr_d = first_beat[1:0];
                        req_addr_d = {plan_addr[first_beat[1:0]], 3'b000};
                        state_d    = StReq;
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StReq: begin
                if (flush) begin
                    if (!cache.req_ready) begin
                        state_d = StIdle;
                    end else begin
                        // Request is leaving now; its response must be swallowed.
                        state_d = cache.resp_valid ? StIdle : StDrain;
                    end
                end else if (cache.req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (flush) begin
                    state_d = cache.resp_valid ? StIdle : StDrain;
                end else if (cache.resp_valid) begin
                    beat_data_d[beat_ptr_q] = cache.resp_data;
                    if (next_beat[2]) begin
                        beat_ptr_d = next_beat[1:0];
                        req_addr_d = {beat_addr_q[next_beat[1:0]], 3'b000};
                        state_d    = StReq;
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (flush || out_ready) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (cache.resp_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_vld_q  <= '0;
            beat_addr_q <= '0;
            beat_data_q <= '0;
            beat_ptr_q  <= '0;
            req_addr_q  <= '0;
            mem1_addr_q <= '0;
            mem2_addr_q <= '0;
            size1_q     <= SizeB;
            size2_q     <= SizeB;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            beat_vld_q  <= beat_vld_d;
            beat_addr_q <= beat_addr_d;
            beat_data_q <= beat_data_d;
            beat_ptr_q  <= beat_ptr_d;
            req_addr_q  <= req_addr_d;
            mem1_addr_q <= mem1_addr_d;
            mem2_addr_q <= mem2_addr_d;
            size1_q     <= size1_d;
            size2_q     <= size2_d;
            rd_q        <= rd_d;
        end
    end

    m_memfetch_align u_align1 (
        .lo_i   (beat_data_q[0]),
        .hi_i   (beat_data_q[1]),
        .off_i  (mem1_addr_q[2:0]),
        .size_i (size1_q),
        .data_o (align1)
    );

    m_memfetch_align u_align2 (
        .lo_i   (beat_data_q[2]),
        .hi_i   (beat_data_q[3]),
        .off_i  (mem2_addr_q[2:0]),
        .size_i (size2_q),
        .data_o (align2)
    );

    assign in_ready        = (state_q == StIdle);
    assign out_valid       = (state_q == StHold);
    assign cache.req_valid = (state_q == StReq);
    assign cache.req_addr  = req_addr_q;
    assign mem1_data       = rd_q[0] ? align1 : 64'd0;
    assign mem2_data       = rd_q[1] ? align2 : 64'd0;
    assign mem1_addr       = mem1_addr_q;
    assign mem2_addr       = mem2_addr_q;

endmodule
